if_pc_stage: RTL

- Instruction-fetch front end. Owns the program counter and selects the next PC from sequential, branch, jump, jump-register, exception and interrupt sources.
- Produces the fetch address for instruction memory and the PC+4 value passed to the IF/ID pipeline register.
- Drives the active-low IF/ID flush and the ID/EX flush.
- Latches pending interrupts and inserts the interrupt redirect only at a safe cycle in user mode. PC[31] is the kernel-mode bit.

---
 rtl/if_pc_stage_pkg.sv | 24 ++
 rtl/if_next_pc_sel.sv | 74 +++++++
 rtl/if_pc_stage.sv | 77 +++++++
 3 files changed

// File: rtl/if_pc_stage_pkg.sv
// Shared constants and PC-source encoding for the instruction-fetch front end.
// Also used by the hazard unit and by bench monitors.
package if_pc_stage_pkg;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam logic [31:0] ILLOP_PC = 32'h8000_0004;
  localparam logic [31:0] XADR_PC  = 32'h8000_0008;

  typedef enum logic [2:0] {
    PC_SEQ   = 3'd0,
    PC_BR    = 3'd1,
    PC_ILLOP = 3'd2,
    PC_JR    = 3'd3,
    PC_J     = 3'd4,
    PC_IRQ   = 3'd5,
    PC_HOLD  = 3'd6
  } pc_src_e;

  // Bit 31 is the kernel-mode bit: the increment wraps within the low 31 bits.
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return {pc[31], pc[30:0] + 31'd4};
  endfunction

endpackage

// File: rtl/if_next_pc_sel.sv
// Combinational next-PC priority mux with flush and exception-save controls.
// Exactly one source wins each cycle; all others are ignored.
module if_next_pc_sel
  import if_pc_stage_pkg::*;
#(
  parameter logic [31:0] ILLOP_PC = if_pc_stage_pkg::ILLOP_PC,
  parameter logic [31:0] XADR_PC  = if_pc_stage_pkg::XADR_PC
) (
  input  logic [31:0] pc,
  input  logic        irq_pending,
  input  logic        pc_write,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic        jr,
  input  logic        illop,
  input  logic [31:0] id_next_pc,
  input  logic [25:0] jt,
  input  logic [31:0] jr_target,
  output logic [31:0] seq_pc,
  output logic [31:0] next_pc,
  output pc_src_e     pc_src,
  output logic        if_id_flush_n,
  output logic        id_ex_flush,
  output logic        exc_save,
  output logic [31:0] epc
);

  assign seq_pc = pc_plus4(pc);

  always_comb begin
    next_pc       = seq_pc;
    pc_src        = PC_SEQ;
    if_id_flush_n = 1'b1;
    id_ex_flush   = 1'b0;
    exc_save      = 1'b0;
    epc           = '0;

    // A resolved branch overrides a load-use stall.
    if (branch_taken) begin
      next_pc       = branch_target;
      pc_src        = PC_BR;
      if_id_flush_n = 1'b0;
      id_ex_flush   = 1'b1;
    end else if (illop && pc_write) begin
      next_pc       = ILLOP_PC;
      pc_src        = PC_ILLOP;
      if_id_flush_n = 1'b0;
      id_ex_flush   = 1'b1;
      exc_save      = 1'b1;
      epc           = id_next_pc;
    end else if (jr && pc_write) begin
      // Kernel bit survives only if the jumping instruction was itself in kernel.
      next_pc       = {jr_target[31] & id_next_pc[31], jr_target[30:0]};
      pc_src        = PC_JR;
      if_id_flush_n = 1'b0;
    end else if (jump && pc_write) begin
      next_pc       = {id_next_pc[31:28], jt, 2'b00};
      pc_src        = PC_J;
      if_id_flush_n = 1'b0;
    end else if (irq_pending && !pc[31] && pc_write) begin
      // The instruction being fetched is discarded and re-executed on return.
      next_pc       = XADR_PC;
      pc_src        = PC_IRQ;
      if_id_flush_n = 1'b0;
      exc_save      = 1'b1;
      epc           = pc;
    end else if (!pc_write) begin
      next_pc       = pc;
      pc_src        = PC_HOLD;
    end
  end

endmodule

// File: rtl/if_pc_stage.sv
// Instruction-fetch front end: owns the PC and the pending-interrupt latch.
// All outputs besides the two registers are combinational.
module if_pc_stage
  import if_pc_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = if_pc_stage_pkg::RESET_PC,
  parameter logic [31:0] ILLOP_PC = if_pc_stage_pkg::ILLOP_PC,
  parameter logic [31:0] XADR_PC  = if_pc_stage_pkg::XADR_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        iPC_Write,
  input  logic        iBranchTaken,
  input  logic [31:0] iBranchTarget,
  input  logic        iJump,
  input  logic        iJR,
  input  logic        iIllop,
  input  logic [31:0] iIDNextPC,
  input  logic [25:0] iJT,
  input  logic [31:0] iJRTarget,
  input  logic        iIRQ,
  input  logic [31:0] iInstrMem,
  output logic [31:0] oPC,
  output logic [31:0] oNextPC,
  output logic [31:0] oInstruction,
  output logic        oIF_ID_Flush_n,
  output logic        oID_EX_Flush,
  output logic        oExcSave,
  output logic [31:0] oEPC,
  output logic        oIRQAck
);

  logic [31:0] pc;
  logic [31:0] next_pc;
  logic        irq_pending;
  pc_src_e     pc_src;

  if_next_pc_sel #(
    .ILLOP_PC (ILLOP_PC),
    .XADR_PC  (XADR_PC)
  ) u_sel (
    .pc            (pc),
    .irq_pending   (irq_pending),
    .pc_write      (iPC_Write),
    .branch_taken  (iBranchTaken),
    .branch_target (iBranchTarget),
    .jump          (iJump),
    .jr            (iJR),
    .illop         (iIllop),
    .id_next_pc    (iIDNextPC),
    .jt            (iJT),
    .jr_target     (iJRTarget),
    .seq_pc        (oNextPC),
    .next_pc       (next_pc),
    .pc_src        (pc_src),
    .if_id_flush_n (oIF_ID_Flush_n),
    .id_ex_flush   (oID_EX_Flush),
    .exc_save      (oExcSave),
    .epc           (oEPC)
  );

  assign oIRQAck      = (pc_src == PC_IRQ);
  assign oPC          = pc;
  assign oInstruction = iInstrMem;

  // A new request in the same cycle as a take keeps the latch set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc          <= RESET_PC;
      irq_pending <= 1'b0;
    end else begin
      pc          <= next_pc;
      irq_pending <= (irq_pending & ~oIRQAck) | iIRQ;
    end
  end

endmodule
